// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: op encodings, sizing constants
// and op-class helpers used by the entry array and the commit controller.
package reorder_buffer_pkg;

  localparam int INST_OP_WIDTH = 6;
  localparam int ROB_SIZE      = 8;
  localparam int ROB_ADDR_W    = 3;
  localparam int DEP_W         = ROB_ADDR_W + 1;

  // Dependency tag meaning "operand comes from the register file".
  localparam logic [DEP_W-1:0] DEP_NONE = '1;

  typedef enum logic [INST_OP_WIDTH-1:0] {
    OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND
  } inst_op_e;

  function automatic logic is_branch(input logic [INST_OP_WIDTH-1:0] op);
    return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
  endfunction

  function automatic logic is_jalr(input logic [INST_OP_WIDTH-1:0] op);
    return op == OP_JALR;
  endfunction

  function automatic logic is_store(input logic [INST_OP_WIDTH-1:0] op);
    return op inside {OP_SB, OP_SH, OP_SW};
  endfunction

endpackage

// File: rtl/reorder_buffer_commit_ctl.sv
// Head-retire controller: decides when the head entry retires, registers the
// commit pulse/data and computes the flush redirect for mispredicts and JALR.
// Optional: ROB_BRANCH_STATS_EN adds saturating branch / flush counters.
module rob_commit_ctl
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_ADDR_W = 3,
  parameter int XLEN       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     head_busy,
  input  logic                     head_done,
  input  logic [INST_OP_WIDTH-1:0] head_op,
  input  logic [4:0]               head_rd,
  input  logic [XLEN-1:0]          head_val,
  input  logic [XLEN-1:0]          head_pc,
  input  logic [XLEN-1:0]          head_imm,
  input  logic                     head_pred,
  input  logic                     head_taken,
  input  logic [XLEN-1:0]          head_target,
  input  logic [ROB_ADDR_W-1:0]    head_id,
  output logic                     pop,
  output logic                     rob_commit_valid,
  output logic [4:0]               rob_commit_rd,
  output logic [XLEN-1:0]          rob_commit_val,
  output logic [ROB_ADDR_W-1:0]    rob_commit_id,
  output logic                     rob_flush,
  output logic [XLEN-1:0]          rob_flush_pc
`ifdef ROB_BRANCH_STATS_EN
  ,
  output logic [31:0]              rob_stat_branches,
  output logic [31:0]              rob_stat_mispredicts
`endif
);

  // Head retires when executed; never in the cycle the flush is being applied.
  assign pop = head_busy && head_done && !rob_flush;

  // Register the retire pulse, retire data and any redirect.
  always_ff @(posedge clk) begin
    if (rst && rdy) begin
      rob_commit_valid <= 1'b0;
      rob_commit_rd    <= '0;
      rob_commit_val   <= '0;
      rob_commit_id    <= '0;
      rob_flush        <= 1'b0;
      rob_flush_pc     <= '0;
    end else if (rdy) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      rob_commit_valid <= pop;
      rob_flush        <= 1'b0;
      if (pop) begin
        rob_commit_rd  <= head_rd;
        rob_commit_val <= head_val;
        rob_commit_id  <= head_id;
        if (is_jalr(head_op)) begin
          rob_flush    <= 1'b1;
          rob_flush_pc <= head_target;
        end else if (is_branch(head_op) && (head_taken != head_pred)) begin
          rob_flush    <= 1'b1;
          rob_flush_pc <= head_taken ? head_pc + head_imm : head_pc + XLEN'(4);
        end
      end
    end
  end

`ifdef ROB_BRANCH_STATS_EN
  // Saturating counts of committed control-flow ops and of applied flushes.
  always_ff @(posedge clk) begin
    if (rst && rdy) begin
      rob_stat_branches    <= '0;
      rob_stat_mispredicts <= '0;
    end else if (rdy) begin
      if (pop && (is_branch(head_op) || is_jalr(head_op)) && (rob_stat_branches != '1))
        rob_stat_branches <= rob_stat_branches + 32'd1;
      if (rob_flush && (rob_stat_mispredicts != '1))
        rob_stat_mispredicts <= rob_stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer top: entry array, allocation at tail, ALU/memory writeback
// capture, operand forwarding to the reservation station and in-order retire
// through rob_commit_ctl.
// Optional: define ROB_BRANCH_STATS_EN for rob_stat_branches/rob_stat_mispredicts.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE   = reorder_buffer_pkg::ROB_SIZE,
  parameter int ROB_ADDR_W = reorder_buffer_pkg::ROB_ADDR_W,
  parameter int DEP_W      = reorder_buffer_pkg::DEP_W,
  parameter int XLEN       = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     stall,
  input  logic                     dec_ready,
  input  logic [INST_OP_WIDTH-1:0] dec_op,
  input  logic                     dec_jump_pred,
  input  logic [4:0]               dec_rd,
  input  logic [XLEN-1:0]          dec_pc,
  input  logic [XLEN-1:0]          dec_imm,
  input  logic                     dec_val_ready,
  input  logic [XLEN-1:0]          dec_val,
  input  logic [DEP_W-1:0]         rf_dep1,
  input  logic [DEP_W-1:0]         rf_dep2,
  input  logic [ROB_ADDR_W-1:0]    rs_remove_id,
  input  logic                     alu_ready,
  input  logic [XLEN-1:0]          alu_res,
  input  logic [ROB_ADDR_W-1:0]    alu_id,
  input  logic                     mem_data_ready,
  input  logic [XLEN-1:0]          mem_data,
  input  logic [ROB_ADDR_W-1:0]    mem_id,
  output logic [ROB_ADDR_W-1:0]    rob_tail_id,
  output logic [ROB_ADDR_W-1:0]    rob_head_id,
  output logic                     rob_full,
  output logic                     rob_Q1_ready,
  output logic [XLEN-1:0]          rob_Q1_val,
  output logic                     rob_Q2_ready,
  output logic [XLEN-1:0]          rob_Q2_val,
  output logic [INST_OP_WIDTH-1:0] rob_rs_remove_op,
  output logic                     rob_commit_valid,
  output logic [4:0]               rob_commit_rd,
  output logic [XLEN-1:0]          rob_commit_val,
  output logic [ROB_ADDR_W-1:0]    rob_commit_id,
  output logic                     rob_flush,
  output logic [XLEN-1:0]          rob_flush_pc
`ifdef ROB_BRANCH_STATS_EN
  ,
  output logic [31:0]              rob_stat_branches,
  output logic [31:0]              rob_stat_mispredicts
`endif
);

  localparam logic [ROB_ADDR_W:0] FULL_COUNT   = (ROB_ADDR_W+1)'(ROB_SIZE);
  localparam logic [DEP_W-1:0]    DEP_ALL_ONES = '1;

  logic [ROB_SIZE-1:0]      busy, val_ready, done, pred, taken;
  logic [INST_OP_WIDTH-1:0] op     [ROB_SIZE];
  logic [4:0]               rd     [ROB_SIZE];
  logic [XLEN-1:0]          pc     [ROB_SIZE];
  logic [XLEN-1:0]          imm    [ROB_SIZE];
  logic [XLEN-1:0]          val    [ROB_SIZE];
  logic [XLEN-1:0]          target [ROB_SIZE];

  logic [ROB_ADDR_W-1:0] head, tail;
  logic [ROB_ADDR_W:0]   count;
  logic                  alloc, pop, alu_wb, mem_wb;

  assign rob_full         = (count == FULL_COUNT);
  assign rob_head_id      = head;
  assign rob_tail_id      = tail;
  assign rob_rs_remove_op = op[rs_remove_id];

  assign alloc  = dec_ready && !stall && !rob_full;
  assign mem_wb = mem_data_ready && busy[mem_id];
  // Memory result wins when both buses name the same entry.
  assign alu_wb = alu_ready && busy[alu_id] && !(mem_data_ready && (mem_id == alu_id));

  // Pointer, occupancy and busy-bit bookkeeping.
  always_ff @(posedge clk) begin
    if (rst && rdy) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      busy  <= '0;
    end else if (rdy) begin
      if (rob_flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
      end else begin
        if (alloc) begin
          busy[tail] <= 1'b1;
          tail       <= tail + 1'b1;
        end
        if (pop) begin
          busy[head] <= 1'b0;
          head       <= head + 1'b1;
        end
        count <= count + (ROB_ADDR_W+1)'(alloc) - (ROB_ADDR_W+1)'(pop);
      end
    end
  end

  // Entry payload: written on allocation and on result writeback.
  // NOTE: payload has no reset; busy alone decides whether an entry is live.
  always_ff @(posedge clk) begin
    if (rdy && !rst && !rob_flush) begin
      if (alloc) begin
        op[tail]   <= dec_op;
        rd[tail]   <= (is_branch(dec_op) || is_store(dec_op)) ? 5'd0 : dec_rd;
        pc[tail]   <= dec_pc;
        imm[tail]  <= dec_imm;
        pred[tail] <= dec_jump_pred;
        if (is_jalr(dec_op)) begin
          val[tail]       <= dec_pc + XLEN'(4);
          val_ready[tail] <= 1'b1;
          done[tail]      <= 1'b0;
        end else begin
          val[tail]       <= dec_val;
          val_ready[tail] <= dec_val_ready;
          done[tail]      <= dec_val_ready;
        end
      end
      if (alu_wb) begin
        done[alu_id] <= 1'b1;
        if (is_branch(op[alu_id])) begin
          taken[alu_id] <= alu_res[0];
        end else if (is_jalr(op[alu_id])) begin
          target[alu_id] <= {alu_res[XLEN-1:1], 1'b0};
        end else begin
          val[alu_id]       <= alu_res;
          val_ready[alu_id] <= 1'b1;
        end
      end
      if (mem_wb) begin
        val[mem_id]       <= mem_data;
        val_ready[mem_id] <= 1'b1;
        done[mem_id]      <= 1'b1;
      end
    end
  end

  // Operand lookup: entry value, then memory bus, then ALU bus; MSB is ready.
  function automatic logic [XLEN:0] forward(input logic [DEP_W-1:0] dep);
    logic [ROB_ADDR_W-1:0] id;
    id      = dep[ROB_ADDR_W-1:0];
    forward = '0;
    if (dep != DEP_ALL_ONES) begin
      if (val_ready[id])                           forward = {1'b1, val[id]};
      else if (mem_data_ready && (mem_id == id))   forward = {1'b1, mem_data};
      else if (alu_ready && (alu_id == id))        forward = {1'b1, alu_res};
    end
  endfunction

  // Combinational forwarding for both source operands.
  always_comb begin
    // NOTE: every output gets a value on every path, so no latch is inferred.
    {rob_Q1_ready, rob_Q1_val} = forward(rf_dep1);
    {rob_Q2_ready, rob_Q2_val} = forward(rf_dep2);
  end

  rob_commit_ctl #(
    .ROB_ADDR_W (ROB_ADDR_W),
    .XLEN       (XLEN)
  ) u_commit_ctl (
    .clk              (clk),
    .rst              (rst),
    .rdy              (rdy),
    .head_busy        (busy[head]),
    .head_done        (done[head]),
    .head_op          (op[head]),
    .head_rd          (rd[head]),
    .head_val         (val[head]),
    .head_pc          (pc[head]),
    .head_imm         (imm[head]),
    .head_pred        (pred[head]),
    .head_taken       (taken[head]),
    .head_target      (target[head]),
    .head_id          (head),
    .pop              (pop),
    .rob_commit_valid (rob_commit_valid),
    .rob_commit_rd    (rob_commit_rd),
    .rob_commit_val   (rob_commit_val),
    .rob_commit_id    (rob_commit_id),
    .rob_flush        (rob_flush),
    .rob_flush_pc     (rob_flush_pc)
`ifdef ROB_BRANCH_STATS_EN
    ,
    .rob_stat_branches    (rob_stat_branches),
    .rob_stat_mispredicts (rob_stat_mispredicts)
`endif
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: directed stimulus pushes expected
// retirements into a queue, a negedge monitor pops and compares each commit.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int XLEN = 32;

  logic                     clk = 1'b0;
  logic                     rst, rdy, stall, dec_ready, dec_jump_pred, dec_val_ready;
  logic [INST_OP_WIDTH-1:0] dec_op;
  logic [4:0]               dec_rd;
  logic [XLEN-1:0]          dec_pc, dec_imm, dec_val;
  logic [3:0]               rf_dep1, rf_dep2;
  logic [2:0]               rs_remove_id, alu_id, mem_id;
  logic                     alu_ready, mem_data_ready;
  logic [XLEN-1:0]          alu_res, mem_data;
  logic [2:0]               rob_tail_id, rob_head_id, rob_commit_id;
  logic                     rob_full, rob_Q1_ready, rob_Q2_ready, rob_commit_valid, rob_flush;
  logic [XLEN-1:0]          rob_Q1_val, rob_Q2_val, rob_commit_val, rob_flush_pc;
  logic [INST_OP_WIDTH-1:0] rob_rs_remove_op;
  logic [4:0]               rob_commit_rd;
`ifdef ROB_BRANCH_STATS_EN
  logic [31:0]              rob_stat_branches, rob_stat_mispredicts;
`endif

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk (clk), .rst (rst), .rdy (rdy), .stall (stall),
    .dec_ready (dec_ready), .dec_op (dec_op), .dec_jump_pred (dec_jump_pred),
    .dec_rd (dec_rd), .dec_pc (dec_pc), .dec_imm (dec_imm),
    .dec_val_ready (dec_val_ready), .dec_val (dec_val),
    .rf_dep1 (rf_dep1), .rf_dep2 (rf_dep2), .rs_remove_id (rs_remove_id),
    .alu_ready (alu_ready), .alu_res (alu_res), .alu_id (alu_id),
    .mem_data_ready (mem_data_ready), .mem_data (mem_data), .mem_id (mem_id),
    .rob_tail_id (rob_tail_id), .rob_head_id (rob_head_id), .rob_full (rob_full),
    .rob_Q1_ready (rob_Q1_ready), .rob_Q1_val (rob_Q1_val),
    .rob_Q2_ready (rob_Q2_ready), .rob_Q2_val (rob_Q2_val),
    .rob_rs_remove_op (rob_rs_remove_op),
    .rob_commit_valid (rob_commit_valid), .rob_commit_rd (rob_commit_rd),
    .rob_commit_val (rob_commit_val), .rob_commit_id (rob_commit_id),
    .rob_flush (rob_flush), .rob_flush_pc (rob_flush_pc)
`ifdef ROB_BRANCH_STATS_EN
    ,
    .rob_stat_branches (rob_stat_branches), .rob_stat_mispredicts (rob_stat_mispredicts)
`endif
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
    logic [2:0]  id;
    logic        chk_val;
    logic        flush;
    logic [31:0] flush_pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_commit(input logic [4:0] rd, input logic [31:0] val, input logic [2:0] id,
                               input logic chk_val, input logic flush, input logic [31:0] fpc);
    exp_t e;
    e.rd = rd; e.val = val; e.id = id; e.chk_val = chk_val; e.flush = flush; e.flush_pc = fpc;
    exp_q.push_back(e);
  endtask

  // Monitor: every commit pulse must match the oldest expected retirement.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rob_commit_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_commit: id %0d rd %0d retired, none expected", rob_commit_id, rob_commit_rd);
      end else begin
        e = exp_q.pop_front();
        check("commit_id", 32'(rob_commit_id), 32'(e.id));
        check("commit_rd", 32'(rob_commit_rd), 32'(e.rd));
        if (e.chk_val) check("commit_val", rob_commit_val, e.val);
        check("commit_flush", 32'(rob_flush), 32'(e.flush));
        if (e.flush) check("flush_pc", rob_flush_pc, e.flush_pc);
      end
    end else if (rob_flush === 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL flush_without_commit: rob_flush=1 with rob_commit_valid=0");
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [INST_OP_WIDTH-1:0] op, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                       input logic vr, input logic [31:0] v);
    dec_ready = 1'b1; dec_op = op; dec_rd = rd; dec_pc = pc; dec_imm = imm;
    dec_jump_pred = pred; dec_val_ready = vr; dec_val = v;
    step();
    dec_ready = 1'b0;
  endtask

  task automatic alu_wb(input logic [2:0] id, input logic [31:0] res);
    alu_ready = 1'b1; alu_id = id; alu_res = res;
    step();
    alu_ready = 1'b0;
  endtask

  task automatic mem_wb(input logic [2:0] id, input logic [31:0] data);
    mem_data_ready = 1'b1; mem_id = id; mem_data = data;
    step();
    mem_data_ready = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0) break;
      step();
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; stall = 1'b0;
    dec_ready = 1'b0; dec_op = OP_NOP; dec_jump_pred = 1'b0; dec_rd = '0;
    dec_pc = '0; dec_imm = '0; dec_val_ready = 1'b0; dec_val = '0;
    rf_dep1 = '1; rf_dep2 = '1; rs_remove_id = '0;
    alu_ready = 1'b0; alu_res = '0; alu_id = '0;
    mem_data_ready = 1'b0; mem_data = '0; mem_id = '0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_full", 32'(rob_full), 0);
    check("rst_tail", 32'(rob_tail_id), 0);
    check("rst_head", 32'(rob_head_id), 0);
    check("rst_commit_valid", 32'(rob_commit_valid), 0);
    check("rst_flush", 32'(rob_flush), 0);
    check("rst_flush_pc", rob_flush_pc, 0);

    // ADDI rd=5 at id 0, ALU writes 7
    expect_commit(5'd5, 32'd7, 3'd0, 1'b1, 1'b0, 32'h0);
    alloc(OP_ADDI, 5'd5, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("addi_tail", 32'(rob_tail_id), 1);
    alu_wb(3'd0, 32'd7);
    wait_drain("addi_drain", 10);
    check("addi_head", 32'(rob_head_id), 1);

    // Forwarding and rs_remove_op: LW rd=3 at id1, ADDI rd=4 at id2
    alloc(OP_LW, 5'd3, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0);
    alloc(OP_ADDI, 5'd4, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0);
    rs_remove_id = 3'd1; #1;
    check("rs_remove_op_1", 32'(rob_rs_remove_op), 32'(OP_LW));
    rs_remove_id = 3'd2; #1;
    check("rs_remove_op_2", 32'(rob_rs_remove_op), 32'(OP_ADDI));
    expect_commit(5'd3, 32'h55, 3'd1, 1'b1, 1'b0, 32'h0);
    expect_commit(5'd4, 32'd9, 3'd2, 1'b1, 1'b0, 32'h0);
    rf_dep1 = 4'd2; rf_dep2 = 4'd1;
    alu_ready = 1'b1; alu_id = 3'd2; alu_res = 32'd9; #1;
    check("q1_alu_bus_ready", 32'(rob_Q1_ready), 1);
    check("q1_alu_bus_val", rob_Q1_val, 32'd9);
    check("q2_not_ready", 32'(rob_Q2_ready), 0);
    step();
    alu_ready = 1'b0; #1;
    check("q1_entry_ready", 32'(rob_Q1_ready), 1);
    check("q1_entry_val", rob_Q1_val, 32'd9);
    rf_dep1 = 4'hF; #1;
    check("q1_none", 32'(rob_Q1_ready), 0);
    mem_data_ready = 1'b1; mem_id = 3'd1; mem_data = 32'h55;
    alu_ready = 1'b1; alu_id = 3'd1; alu_res = 32'h66; #1;
    check("q2_mem_over_alu_ready", 32'(rob_Q2_ready), 1);
    check("q2_mem_over_alu_val", rob_Q2_val, 32'h55);
    step();
    mem_data_ready = 1'b0; alu_ready = 1'b0; rf_dep2 = 4'hF;
    wait_drain("fwd_drain", 10);

    // Reset with 5 busy entries (ids 3..7)
    for (int i = 0; i < 5; i++) alloc(OP_ADDI, 5'(i + 10), 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("five_tail", 32'(rob_tail_id), 0);
    pulse_rst();
    check("midrst_full", 32'(rob_full), 0);
    check("midrst_tail", 32'(rob_tail_id), 0);
    check("midrst_head", 32'(rob_head_id), 0);
    check("midrst_commit_valid", 32'(rob_commit_valid), 0);

    // Fill all 8 entries, then a 9th decode is held off until a slot frees
    for (int i = 0; i < 8; i++) alloc(OP_ADDI, 5'(i + 1), 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    check("fill_full", 32'(rob_full), 1);
    check("fill_tail", 32'(rob_tail_id), 0);
    dec_ready = 1'b1; dec_op = OP_ADDI; dec_rd = 5'd9; dec_val_ready = 1'b0;
    step();
    check("ninth_ignored_tail", 32'(rob_tail_id), 0);
    check("ninth_ignored_full", 32'(rob_full), 1);
    expect_commit(5'd1, 32'h100, 3'd0, 1'b1, 1'b0, 32'h0);
    alu_wb(3'd0, 32'h100);
    check("wb_full_tail", 32'(rob_tail_id), 0);
    step();
    check("commit_full_tail", 32'(rob_tail_id), 0);
    check("commit_full_notfull", 32'(rob_full), 0);
    step();
    dec_ready = 1'b0;
    check("wrap_alloc_tail", 32'(rob_tail_id), 1);
    check("wrap_alloc_full", 32'(rob_full), 1);
    wait_drain("full_drain", 5);
    pulse_rst();

    // BEQ mispredict: pred=0, taken=1 -> redirect to 0x120
    expect_commit(5'd0, 32'h0, 3'd0, 1'b0, 1'b1, 32'h120);
    alloc(OP_BEQ, 5'd7, 32'h100, 32'h20, 1'b0, 1'b0, 32'h0);
    alloc(OP_ADDI, 5'd2, 32'h104, 32'h0, 1'b0, 1'b0, 32'h0);
    check("beq_tail", 32'(rob_tail_id), 2);
    alu_wb(3'd1, 32'h33);
    alu_wb(3'd0, 32'h1);
    step();
    dec_ready = 1'b1; dec_op = OP_ADDI; dec_rd = 5'd8;
    alu_ready = 1'b1; alu_id = 3'd1; alu_res = 32'h77;
    step();
    dec_ready = 1'b0; alu_ready = 1'b0;
    check("beq_flushed_tail", 32'(rob_tail_id), 0);
    check("beq_flushed_head", 32'(rob_head_id), 0);
    check("beq_flushed_full", 32'(rob_full), 0);
    check("beq_flush_dropped", 32'(rob_flush), 0);
    step();
    step();
    check("beq_no_late_commit_head", 32'(rob_head_id), 0);
    wait_drain("beq_drain", 2);

    // JALR pc=0x40, ALU target 0x203 -> link 0x44, redirect 0x202
    expect_commit(5'd1, 32'h44, 3'd0, 1'b1, 1'b1, 32'h202);
    alloc(OP_JALR, 5'd1, 32'h40, 32'h0, 1'b0, 1'b0, 32'hDEAD);
    alu_wb(3'd0, 32'h203);
    wait_drain("jalr_drain", 10);
    step();
    check("jalr_cleared_tail", 32'(rob_tail_id), 0);

    // Stall blocks allocation
    stall = 1'b1; dec_ready = 1'b1; dec_op = OP_ADDI;
    step();
    stall = 1'b0; dec_ready = 1'b0;
    check("stall_tail", 32'(rob_tail_id), 0);

    // LUI retires one edge after allocation; SW rd forced 0; BNE predicted right
    expect_commit(5'd6, 32'h12345000, 3'd0, 1'b1, 1'b0, 32'h0);
    expect_commit(5'd0, 32'hABCD, 3'd1, 1'b1, 1'b0, 32'h0);
    expect_commit(5'd0, 32'h0, 3'd2, 1'b0, 1'b0, 32'h0);
    alloc(OP_LUI, 5'd6, 32'h200, 32'h0, 1'b0, 1'b1, 32'h12345000);
    alloc(OP_SW, 5'd9, 32'h204, 32'h0, 1'b0, 1'b0, 32'h0);
    check("lui_commit_timing", 32'(rob_commit_valid), 1);
    alloc(OP_BNE, 5'd3, 32'h208, 32'h10, 1'b1, 1'b0, 32'h0);
    mem_wb(3'd1, 32'hABCD);
    alu_wb(3'd2, 32'h1);
    wait_drain("final_drain", 10);
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
